// File: rtl/irq_trap_ctrl_pkg.sv
// Shared machine-mode CSR definitions for the interrupt/trap controller:
// CSR addresses, interrupt cause codes, the sequencer state type and the priority pick.
package irq_trap_ctrl_pkg;

  localparam logic [11:0] CSR_MIE    = 12'h304;
  localparam logic [11:0] CSR_MEPC   = 12'h341;
  localparam logic [11:0] CSR_MCAUSE = 12'h342;
  localparam logic [11:0] CSR_MIP    = 12'h344;

  localparam logic [31:0] CAUSE_MEI = 32'h8000_000B;
  localparam logic [31:0] CAUSE_MSI = 32'h8000_0003;
  localparam logic [31:0] CAUSE_MTI = 32'h8000_0007;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PEND,
    ST_TRAP,
    ST_RET
  } trap_state_e;

  // pend is {mei, msi, mti}; MEI outranks MSI, which outranks MTI.
  function automatic logic [31:0] pick_cause(input logic [2:0] pend);
    logic [31:0] cause;
    if (pend[2]) begin
      cause = CAUSE_MEI;
    end else if (pend[1]) begin
      cause = CAUSE_MSI;
    end else begin
      cause = CAUSE_MTI;
    end
    return cause;
  endfunction

endpackage

// File: rtl/irq_sync2.sv
// Two-flop synchroniser bringing one asynchronous interrupt level into the core clock domain.
module irq_sync2 (
  input  logic clock,
  input  logic rst_in,
  input  logic async_in,
  output logic sync_out
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clock or posedge rst_in) begin
    if (rst_in) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= async_in;
      sync_q <= meta_q;
    end
  end

  assign sync_out = sync_q;

endmodule

// File: rtl/irq_trap_ctrl.sv
// Machine-mode interrupt arbiter and trap-entry / mret sequencer; owns mip, mepc and mcause.
// Define MTVEC_VECTORED_EN to honour vectored mtvec mode (mode bits 2'b01) for interrupt traps.
module irq_trap_ctrl
  import irq_trap_ctrl_pkg::*;
#(
  parameter logic [11:0] MEPC   = CSR_MEPC,
  parameter logic [11:0] MCAUSE = CSR_MCAUSE,
  parameter logic [11:0] MIP    = CSR_MIP
) (
  input  logic        clock,
  input  logic        rst_in,
  input  logic        meie_in,
  input  logic        mtie_in,
  input  logic        msie_in,
  input  logic        mstatus_mie_in,
  input  logic        e_irq_in,
  input  logic        t_irq_in,
  input  logic        s_irq_in,
  input  logic        retire_in,
  input  logic [31:0] next_pc_in,
  input  logic        mret_in,
  input  logic [31:0] mtvec_in,
  input  logic        trap_ack_in,
  input  logic        wr_en_in,
  input  logic [11:0] csr_addr_in,
  input  logic [31:0] data_wr_in,
  output logic        trap_req_out,
  output logic [31:0] trap_addr_out,
  output logic        mie_clear_out,
  output logic        mie_restore_out,
  output logic [31:0] mip_reg_out,
  output logic [31:0] mepc_out,
  output logic [31:0] mcause_out
);

  logic meip;
  logic mtip;
  logic msip;

  irq_sync2 u_sync_mei (
    .clock    (clock),
    .rst_in   (rst_in),
    .async_in (e_irq_in),
    .sync_out (meip)
  );

  irq_sync2 u_sync_mti (
    .clock    (clock),
    .rst_in   (rst_in),
    .async_in (t_irq_in),
    .sync_out (mtip)
  );

  irq_sync2 u_sync_msi (
    .clock    (clock),
    .rst_in   (rst_in),
    .async_in (s_irq_in),
    .sync_out (msip)
  );

  logic [2:0] pend;
  logic       irq_take;
  logic       mret_retire;

  assign pend        = {meip & meie_in, msip & msie_in, mtip & mtie_in};
  assign irq_take    = (|pend) & mstatus_mie_in;
  assign mret_retire = retire_in & mret_in;

  trap_state_e state_q;
  trap_state_e state_d;
  logic        take_trap;
  logic        enter_ret;

  always_ff @(posedge clock or posedge rst_in) begin
    if (rst_in) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Interrupts are level-sensitive: PEND only survives while the request is still live,
  // and an mret retiring in IDLE or PEND always wins over taking the interrupt.
  always_comb begin
    state_d   = state_q;
    take_trap = 1'b0;
    enter_ret = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mret_retire) begin
          state_d   = ST_RET;
          enter_ret = 1'b1;
        end else if (irq_take) begin
          state_d = ST_PEND;
        end
      end
      ST_PEND: begin
        if (mret_retire) begin
          state_d   = ST_RET;
          enter_ret = 1'b1;
        end else if (!irq_take) begin
          state_d = ST_IDLE;
        end else if (retire_in) begin
          state_d   = ST_TRAP;
          take_trap = 1'b1;
        end
      end
      ST_TRAP, ST_RET: begin
        if (trap_ack_in) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  logic wr_mepc;
  logic wr_mcause;

  always_comb begin
    wr_mepc   = 1'b0;
    wr_mcause = 1'b0;
    if (wr_en_in) begin
      case (csr_addr_in)
        MEPC:    wr_mepc = 1'b1;
        MCAUSE:  wr_mcause = 1'b1;
        MIP:     ;
        default: ;
      endcase
    end
  end

  logic [31:0] mepc_q;
  logic [31:0] mepc_d;
  logic [31:0] mcause_q;
  logic [31:0] mcause_d;
  logic        mie_clear_q;
  logic        mie_restore_q;

  // Trap entry owns both CSRs in its cycle, so a coincident software write is dropped.
  always_comb begin
    mepc_d   = mepc_q;
    mcause_d = mcause_q;
    if (take_trap) begin
      mepc_d   = next_pc_in;
      mcause_d = pick_cause(pend);
    end else begin
      if (wr_mepc) begin
        mepc_d = {data_wr_in[31:2], 2'b00};
      end
      if (wr_mcause) begin
        mcause_d = data_wr_in;
      end
    end
  end

  always_ff @(posedge clock or posedge rst_in) begin
    if (rst_in) begin
      mepc_q        <= 32'b0;
      mcause_q      <= 32'b0;
      mie_clear_q   <= 1'b0;
      mie_restore_q <= 1'b0;
    end else begin
      mepc_q        <= mepc_d;
      mcause_q      <= mcause_d;
      mie_clear_q   <= take_trap;
      mie_restore_q <= enter_ret;
    end
  end

  logic [31:0] vec_base;
  logic [31:0] trap_target;

  always_comb begin
    vec_base    = mtvec_in & 32'hFFFF_FFFC;
    trap_target = vec_base;
`ifdef MTVEC_VECTORED_EN
    if (mtvec_in[1:0] == 2'b01) begin
      trap_target = vec_base + {26'b0, mcause_q[3:0], 2'b00};
    end
`endif
    trap_addr_out = 32'b0;
    case (state_q)
      ST_TRAP: trap_addr_out = trap_target;
      ST_RET:  trap_addr_out = mepc_q;
      default: trap_addr_out = 32'b0;
    endcase
  end

  assign trap_req_out    = (state_q == ST_TRAP) || (state_q == ST_RET);
  assign mie_clear_out   = mie_clear_q;
  assign mie_restore_out = mie_restore_q;
  assign mip_reg_out     = {20'b0, meip, 3'b0, mtip, 3'b0, msip, 3'b0};
  assign mepc_out        = mepc_q;
  assign mcause_out      = mcause_q;

endmodule

// File: doc/irq_trap_ctrl.md
# irq_trap_ctrl

Machine-mode interrupt arbiter and trap-entry sequencer for the RISC-V core. It sits directly downstream of the machine interrupt-enable CSR and consumes its meie/mtie/msie bits. It combines them with synchronised pending sources and the global mstatus.MIE bit, then sequences trap entry and `mret` return with the fetch/pipeline control. It also owns the mip view plus the mepc and mcause CSRs.

## Interface
Parameters:
- MEPC = 12'h341, CSR address of mepc
- MCAUSE = 12'h342, CSR address of mcause
- MIP = 12'h344, CSR address of mip (read-only)

Ports:
- clock  in  1  core clock, single clock domain
- rst_in  in  1  reset, asynchronous, active-high
- meie_in / mtie_in / msie_in  in  1 each  enable bits from mie CSR
- mstatus_mie_in  in  1  global interrupt enable
- e_irq_in / t_irq_in / s_irq_in  in  1 each  raw external/timer/software pending levels (asynchronous)
- retire_in  in  1  instruction boundary this cycle
- next_pc_in  in  32  PC of the next unexecuted instruction when retire_in=1
- mret_in  in  1  retiring instruction is `mret` (qualified by retire_in)
- mtvec_in  in  32  trap vector CSR value
- trap_ack_in  in  1  pipeline has flushed and accepted the redirect
- wr_en_in  in  1  CSR write strobe
- csr_addr_in  in  12  CSR address
- data_wr_in  in  32  CSR write data
- trap_req_out  out  1  redirect request, held until ack
- trap_addr_out  out  32  redirect target
- mie_clear_out  out  1  one-cycle pulse: MPIE<=MIE, MIE<=0
- mie_restore_out  out  1  one-cycle pulse: MIE<=MPIE, MPIE<=1
- mip_reg_out / mepc_out / mcause_out  out  32 each  CSR read values

## Operation
- Each raw irq passes through a 2-flop synchroniser, giving meip/mtip/msip. mip_reg_out = {20'b0, meip, 3'b0, mtip, 3'b0, msip, 3'b0}. Writes to MIP are ignored.
- pend = {meip&meie_in, msip&msie_in, mtip&mtie_in}. Priority is MEI > MSI > MTI. Cause codes are 0x8000000B, 0x80000003, 0x80000007.
- FSM states IDLE, PEND, TRAP, RET:
  - IDLE -> PEND: |pend & mstatus_mie_in.
  - IDLE -> RET: retire_in & mret_in. The mret check has priority over the IDLE -> PEND transition.
  - PEND -> IDLE: pending or global enable drops. Interrupts are level-sensitive and nothing is latched.
  - PEND -> TRAP: retire_in & ~mret_in. On this transition, mepc <= next_pc_in, mcause <= highest-priority cause (recomputed that cycle), and mie_clear_out pulses.
  - PEND -> RET: retire_in & mret_in. The interrupt is re-evaluated afterwards.
  - TRAP: trap_req_out=1 and trap_addr_out is stable. On trap_ack_in -> IDLE.
  - RET: trap_req_out=1 and trap_addr_out=mepc, with mie_restore_out pulsed on entry. On trap_ack_in -> IDLE.
- CSR writes: mepc <= {data_wr_in[31:2],2'b00}; mcause <= data_wr_in. A hardware update in the same cycle takes precedence over a CSR write.
- mepc/mcause are not changed by RET.

## Timing
- Reset values: all outputs 0; mepc = 0, mcause = 0, synchronisers = 0, FSM in IDLE. trap_req_out deasserts immediately when reset is asserted mid-sequence.
- Synchroniser latency: 2 cycles from a raw irq to meip/mtip/msip.
- Earliest trap_req_out: 1 cycle after the PEND -> TRAP transition edge (registered output).
- mie_clear_out/mie_restore_out are exactly 1 cycle wide and coincide with the first cycle of trap_req_out.
- trap_ack_in is ignored in IDLE and PEND. An ack in the first cycle of trap_req_out is legal, giving a minimum 1-cycle request.

## Configuration
- MTVEC_VECTORED_EN defined: if mtvec_in[1:0]==2'b01, trap_addr_out = {mtvec_in[31:2],2'b00} + 4*mcause[3:0].
- MTVEC_VECTORED_EN undefined: trap_addr_out = {mtvec_in[31:2],2'b00} always, whatever the mode bits.
- RET target is mepc in both cases.

## Structure
- The shared CSR package holds:
  - the CSR address constants (MIE, MIP, MEPC, MCAUSE);
  - the cause-code constants;
  - the FSM state typedef.
- One sub-module, `irq_sync2`: a 2-flop synchroniser with asynchronous active-high reset. It is instantiated three times.

## Test plan
- e_irq_in=1, meie_in=1, mstatus_mie_in=1, retire_in with next_pc_in=0x100, mtvec=0x8000_0000 -> mcause=0x8000000B, mepc=0x100, trap_addr_out=0x8000_0000, mie_clear_out for 1 cycle, trap_req_out held until trap_ack_in.
- All three irqs pending and enabled -> MEI taken first. Drop e_irq_in, then ack, then retire -> cause 0x80000003.
- Pending irq enters PEND, then mtie_in drops before retire -> return to IDLE with no trap_req_out and mepc unchanged.
- mret retires with mepc=0x240 -> trap_addr_out=0x240, mie_restore_out pulse, IDLE after ack.
- With MTVEC_VECTORED_EN, mtvec=0x1001 and a timer irq -> target 0x101C. Without the macro -> target 0x1000.
- Assert rst_in while in TRAP -> trap_req_out=0 asynchronously, mepc=mcause=0, and no trap is taken until a fresh PEND.
